// File: rtl/pcmd_parser_gen2.sv
// pcmd_parser_gen2: queued command parser. Commands are buffered in a small
// FIFO and then decoded one at a time. A command either updates the local
// per-channel configuration (mux select, clock enable) or is forwarded to a
// single downstream channel. Every command ends with exactly one response.
//
// Handshakes: a transfer happens on a rising sys_clk edge where valid and
// ready are both high. A valid, once raised, stays high with its payload
// unchanged until that transfer happens. Ready may toggle freely and never
// depends on valid within the same cycle.
module pcmd_parser_gen2 #(
    parameter int NUM_CH  = 4,
    parameter int ARG_W   = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255,
    parameter int CH_W    = 4
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    cmd_in_valid,
    output logic                    cmd_in_ready,
    input  logic [3:0]              cmd_in_op,
    input  logic [CH_W-1:0]         cmd_in_ch,
    input  logic [ARG_W-1:0]        cmd_in_arg,
    output logic [$clog2(DEPTH):0]  cmd_level,
    output logic [NUM_CH-1:0]       ch_op_valid,
    input  logic [NUM_CH-1:0]       ch_op_ready,
    output logic                    ch_op_wr,
    output logic [ARG_W-1:0]        ch_op_data,
    input  logic [NUM_CH*ARG_W-1:0] ch_rdata,
    output logic [2*NUM_CH-1:0]     mux_sel,
    output logic [NUM_CH-1:0]       ch_clk_en,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_code,
    output logic [ARG_W-1:0]        rsp_data,
    output logic [7:0]              illegal_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_READ   = 4'h2;
    localparam logic [3:0] OP_MUXCFG = 4'h3;
    localparam logic [3:0] OP_CLKEN  = 4'h4;

    localparam logic [1:0] RSP_OK       = 2'd0;
    localparam logic [1:0] RSP_ILLEGAL  = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT  = 2'd2;
    localparam logic [1:0] RSP_DISABLED = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Command queue storage and bookkeeping
    logic [3:0]       op_mem  [DEPTH];
    logic [CH_W-1:0]  ch_mem  [DEPTH];
    logic [ARG_W-1:0] arg_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             cmd_in_ready_q, cmd_in_ready_d;
    logic             push, pop;

    // Command being executed
    logic [3:0]       cmd_op_q, cmd_op_d;
    logic [CH_W-1:0]  cmd_ch_q, cmd_ch_d;
    logic [ARG_W-1:0] cmd_arg_q, cmd_arg_d;

    // Registered outputs and timer
    logic [NUM_CH-1:0]   ch_op_valid_q, ch_op_valid_d;
    logic                ch_op_wr_q, ch_op_wr_d;
    logic [ARG_W-1:0]    ch_op_data_q, ch_op_data_d;
    logic [2*NUM_CH-1:0] mux_sel_q, mux_sel_d;
    logic [NUM_CH-1:0]   ch_clk_en_q, ch_clk_en_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [1:0]          rsp_code_q, rsp_code_d;
    logic [ARG_W-1:0]    rsp_data_q, rsp_data_d;
    logic [7:0]          illegal_cnt_q, illegal_cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    // Decoded view of the addressed channel
    logic [NUM_CH-1:0] sel_onehot;
    logic              sel_en;
    logic              sel_ready;
    logic [ARG_W-1:0]  sel_rdata;
    logic              ch_in_range;

    // Decode the command channel; an out-of-range index selects nothing
    always_comb begin
        sel_onehot = '0;
        sel_en     = 1'b0;
        sel_ready  = 1'b0;
        sel_rdata  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cmd_ch_q == CH_W'(c)) begin
                sel_onehot[c] = 1'b1;
                sel_en        = ch_clk_en_q[c];
                sel_ready     = ch_op_ready[c];
                sel_rdata     = ch_rdata[c*ARG_W +: ARG_W];
            end
        end
    end

    assign ch_in_range = |sel_onehot;

    assign push = cmd_in_valid && cmd_in_ready_q;
    assign pop  = (state_q == ST_IDLE) && (level_q != '0);

    // Queue pointers and occupancy; ready is registered from the next level
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;
        cmd_in_ready_d = (level_d != LVL_W'(DEPTH));
    end

    // Queue storage needs no reset: level and pointers define valid entries
    always_ff @(posedge sys_clk) begin
        if (push) begin
            op_mem[wr_ptr_q]  <= cmd_in_op;
            ch_mem[wr_ptr_q]  <= cmd_in_ch;
            arg_mem[wr_ptr_q] <= cmd_in_arg;
        end
    end

    // Command FSM: next state and all registered outputs
    always_comb begin
        state_d       = state_q;
        cmd_op_d      = cmd_op_q;
        cmd_ch_d      = cmd_ch_q;
        cmd_arg_d     = cmd_arg_q;
        ch_op_valid_d = ch_op_valid_q;
        ch_op_wr_d    = ch_op_wr_q;
        ch_op_data_d  = ch_op_data_q;
        mux_sel_d     = mux_sel_q;
        ch_clk_en_d   = ch_clk_en_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_code_d    = rsp_code_q;
        rsp_data_d    = rsp_data_q;
        illegal_cnt_d = illegal_cnt_q;
        timer_d       = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    cmd_op_d  = op_mem[rd_ptr_q];
                    cmd_ch_d  = ch_mem[rd_ptr_q];
                    cmd_arg_d = arg_mem[rd_ptr_q];
                    state_d   = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // Most outcomes respond immediately; the launch case overrides
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_code_d  = RSP_OK;
                rsp_data_d  = '0;
                if (cmd_op_q > OP_CLKEN || (cmd_op_q != OP_NOP && !ch_in_range)) begin
                    rsp_code_d = RSP_ILLEGAL;
                    if (illegal_cnt_q != 8'hFF) illegal_cnt_d = illegal_cnt_q + 8'd1;
                end else if (cmd_op_q == OP_MUXCFG) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (sel_onehot[c]) mux_sel_d[2*c +: 2] = cmd_arg_q[1:0];
                    end
                end else if (cmd_op_q == OP_CLKEN) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (sel_onehot[c]) ch_clk_en_d[c] = cmd_arg_q[0];
                    end
                end else if (cmd_op_q != OP_NOP) begin
                    if (!sel_en) begin
                        rsp_code_d = RSP_DISABLED;
                    end else begin
                        rsp_valid_d   = 1'b0;
                        ch_op_valid_d = sel_onehot;
                        ch_op_wr_d    = (cmd_op_q == OP_WRITE);
                        ch_op_data_d  = cmd_arg_q;
                        timer_d       = '0;
                        state_d       = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // Ready on the final timer edge still wins over the timeout
                if (sel_ready) begin
                    ch_op_valid_d = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_code_d    = RSP_OK;
                    rsp_data_d    = (cmd_op_q == OP_READ) ? sel_rdata : '0;
                    state_d       = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    ch_op_valid_d = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_code_d    = RSP_TIMEOUT;
                    rsp_data_d    = '0;
                    timer_d       = timer_q + 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            cmd_in_ready_q <= 1'b1;
            cmd_op_q       <= '0;
            cmd_ch_q       <= '0;
            cmd_arg_q      <= '0;
            ch_op_valid_q  <= '0;
            ch_op_wr_q     <= 1'b0;
            ch_op_data_q   <= '0;
            mux_sel_q      <= '0;
            ch_clk_en_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_code_q     <= '0;
            rsp_data_q     <= '0;
            illegal_cnt_q  <= '0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            cmd_in_ready_q <= cmd_in_ready_d;
            cmd_op_q       <= cmd_op_d;
            cmd_ch_q       <= cmd_ch_d;
            cmd_arg_q      <= cmd_arg_d;
            ch_op_valid_q  <= ch_op_valid_d;
            ch_op_wr_q     <= ch_op_wr_d;
            ch_op_data_q   <= ch_op_data_d;
            mux_sel_q      <= mux_sel_d;
            ch_clk_en_q    <= ch_clk_en_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_code_q     <= rsp_code_d;
            rsp_data_q     <= rsp_data_d;
            illegal_cnt_q  <= illegal_cnt_d;
            timer_q        <= timer_d;
        end
    end

    assign cmd_in_ready = cmd_in_ready_q;
    assign cmd_level    = level_q;
    assign ch_op_valid  = ch_op_valid_q;
    assign ch_op_wr     = ch_op_wr_q;
    assign ch_op_data   = ch_op_data_q;
    assign mux_sel      = mux_sel_q;
    assign ch_clk_en    = ch_clk_en_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_code     = rsp_code_q;
    assign rsp_data     = rsp_data_q;
    assign illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_pcmd_parser_gen2.sv
// Testbench for pcmd_parser_gen2: commands are modelled when accepted, the
// expected response is queued, and independent responder/monitor processes
// play the downstream channels and the response consumer.
module tb_pcmd_parser_gen2;

    localparam int NUM_CH  = 4;
    localparam int ARG_W   = 8;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;
    localparam int CH_W    = 4;
    localparam int EW      = 2 + ARG_W + 2*NUM_CH + NUM_CH + 8;

    logic                    sys_clk = 1'b0;
    logic                    sys_rst = 1'b1;
    logic                    cmd_in_valid;
    logic                    cmd_in_ready;
    logic [3:0]              cmd_in_op;
    logic [CH_W-1:0]         cmd_in_ch;
    logic [ARG_W-1:0]        cmd_in_arg;
    logic [$clog2(DEPTH):0]  cmd_level;
    logic [NUM_CH-1:0]       ch_op_valid;
    logic [NUM_CH-1:0]       ch_op_ready;
    logic                    ch_op_wr;
    logic [ARG_W-1:0]        ch_op_data;
    logic [NUM_CH*ARG_W-1:0] ch_rdata;
    logic [2*NUM_CH-1:0]     mux_sel;
    logic [NUM_CH-1:0]       ch_clk_en;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [1:0]              rsp_code;
    logic [ARG_W-1:0]        rsp_data;
    logic [7:0]              illegal_cnt;

    pcmd_parser_gen2 #(
        .NUM_CH(NUM_CH), .ARG_W(ARG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CH_W(CH_W)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_in_valid(cmd_in_valid), .cmd_in_ready(cmd_in_ready),
        .cmd_in_op(cmd_in_op), .cmd_in_ch(cmd_in_ch), .cmd_in_arg(cmd_in_arg),
        .cmd_level(cmd_level),
        .ch_op_valid(ch_op_valid), .ch_op_ready(ch_op_ready),
        .ch_op_wr(ch_op_wr), .ch_op_data(ch_op_data), .ch_rdata(ch_rdata),
        .mux_sel(mux_sel), .ch_clk_en(ch_clk_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_code(rsp_code), .rsp_data(rsp_data), .illegal_cnt(illegal_cnt)
    );

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int               ch;
        bit               wr;
        logic [ARG_W-1:0] data;
        int               delay;
        bit               never;
        logic [ARG_W-1:0] rdata;
    } plan_t;

    plan_t          plan_q[$];
    logic [EW-1:0]  exp_q[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    int             mux_m[NUM_CH];
    int             en_m[NUM_CH];
    int             ill_m = 0;
    bit             rsp_hold = 1'b0;
    bit             abort_op = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] pack_exp(input int code, input int data);
        logic [2*NUM_CH-1:0] mv;
        logic [NUM_CH-1:0]   ev;
        for (int c = 0; c < NUM_CH; c++) begin
            mv[2*c +: 2] = 2'(mux_m[c]);
            ev[c]        = (en_m[c] != 0);
        end
        return {2'(code), ARG_W'(data), mv, ev, 8'(ill_m)};
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mux_m[c] = 0;
            en_m[c]  = 0;
        end
        ill_m = 0;
    endfunction

    // Reference behaviour of one command, applied in acceptance order
    task automatic model_cmd(input int op, input int ch, input int arg,
                             input int delay, input bit never, input int rdata);
        plan_t p;
        int code = 0;
        int data = 0;
        if (op > 4 || (op != 0 && ch >= NUM_CH)) begin
            code = 1;
            if (ill_m < 255) ill_m++;
        end else if (op == 3) begin
            mux_m[ch] = arg % 4;
        end else if (op == 4) begin
            en_m[ch] = arg % 2;
        end else if (op == 1 || op == 2) begin
            if (en_m[ch] == 0) begin
                code = 3;
            end else begin
                p.ch = ch; p.wr = (op == 1); p.data = ARG_W'(arg);
                p.delay = delay; p.never = never; p.rdata = ARG_W'(rdata);
                plan_q.push_back(p);
                if (never)        code = 2;
                else if (op == 2) data = rdata;
            end
        end
        exp_q.push_back(pack_exp(code, data));
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send(input int op, input int ch, input int arg, input int delay,
                        input bit never, input int rdata, input int max_wait, output bit acc);
        int n = 0;
        cmd_in_valid = 1'b1;
        cmd_in_op    = 4'(op);
        cmd_in_ch    = CH_W'(ch);
        cmd_in_arg   = ARG_W'(arg);
        while (!cmd_in_ready && n < max_wait) begin
            @(negedge sys_clk);
            n++;
        end
        acc = cmd_in_ready;
        if (acc) begin
            model_cmd(op, ch, arg, delay, never, rdata);
            @(negedge sys_clk);
        end
        cmd_in_valid = 1'b0;
    endtask

    task automatic send_ok(input int op, input int ch, input int arg, input int delay,
                           input bit never, input int rdata);
        bit acc;
        send(op, ch, arg, delay, never, rdata, 3000, acc);
        check("push_accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || cmd_level != '0 || ch_op_valid != '0) && n < 5000) begin
            @(negedge sys_clk);
            n++;
        end
        check("drain_in_budget", 64'(n < 5000), 64'd1);
        repeat (2) @(negedge sys_clk);
    endtask

    // ---------------- downstream channel responder ----------------
    initial begin : responder
        plan_t p;
        int    held;
        bit    unexpected;
        ch_op_ready = '0;
        ch_rdata    = '0;
        forever begin
            @(negedge sys_clk);
            if (ch_op_valid != '0 && !sys_rst) begin
                unexpected = 1'b0;
                if (plan_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL op_unexpected: ch_op_valid=%b with no operation expected", ch_op_valid);
                    unexpected = 1'b1;
                    p.ch = 0; p.never = 1'b1; p.delay = 0;
                end else begin
                    p = plan_q.pop_front();
                    check("op_select", 64'(ch_op_valid), 64'd1 << p.ch);
                    check("op_wr", 64'(ch_op_wr), 64'(p.wr));
                    check("op_data", 64'(ch_op_data), 64'(p.data));
                end
                held = 0;
                while (ch_op_valid != '0 && held < TIMEOUT + 20) begin
                    held++;
                    ch_op_ready = NUM_CH'($urandom) & ~(NUM_CH'(1) << p.ch);
                    ch_rdata    = (NUM_CH*ARG_W)'($urandom);
                    if (!p.never && held >= p.delay) begin
                        ch_op_ready[p.ch] = 1'b1;
                        ch_rdata[p.ch*ARG_W +: ARG_W] = p.rdata;
                    end
                    @(negedge sys_clk);
                end
                ch_op_ready = '0;
                if (!abort_op && !unexpected)
                    check("op_hold_cycles", 64'(held), 64'(p.never ? TIMEOUT : p.delay));
            end else begin
                ch_op_ready = NUM_CH'($urandom);
                ch_rdata    = (NUM_CH*ARG_W)'($urandom);
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : monitor
        logic [EW-1:0] a;
        logic [EW-1:0] e;
        bit            r;
        rsp_ready = 1'b0;
        forever begin
            @(negedge sys_clk);
            r = !rsp_hold && ($urandom_range(0, 9) < 7);
            rsp_ready = r;
            if (rsp_valid && r && !sys_rst) begin
                a = {rsp_code, rsp_data, mux_sel, ch_clk_en, illegal_cnt};
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got 0x%0h with nothing expected", a);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp{code,data,mux,en,ill}", 64'(a), 64'(e));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #900000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: run exceeded its time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin : main
        bit acc;
        int n_acc;
        int n;
        int r;
        int op;
        int ch;
        bit never;

        cmd_in_valid = 1'b0;
        cmd_in_op    = '0;
        cmd_in_ch    = '0;
        cmd_in_arg   = '0;
        model_reset();

        // Reset values
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_cmd_level", 64'(cmd_level), 64'd0);
        check("rst_cmd_in_ready", 64'(cmd_in_ready), 64'd1);
        check("rst_ch_op_valid", 64'(ch_op_valid), 64'd0);
        check("rst_ch_op_wr", 64'(ch_op_wr), 64'd0);
        check("rst_ch_op_data", 64'(ch_op_data), 64'd0);
        check("rst_mux_sel", 64'(mux_sel), 64'd0);
        check("rst_ch_clk_en", 64'(ch_clk_en), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_code", 64'(rsp_code), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // MUXCFG ch=2 arg=2: response appears after the second edge
        send_ok(3, 2, 2, 0, 1'b0, 0);
        @(posedge sys_clk); #1;
        check("lat_local_e1_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge sys_clk); #1;
        check("lat_local_e2_rsp_valid", 64'(rsp_valid), 64'd1);
        check("lat_local_e2_mux_sel", 64'(mux_sel), 64'h20);
        @(negedge sys_clk);
        wait_idle();

        // CLKEN ch=1, then READ ch=1 answered after 3 cycles with 0xA5
        send_ok(4, 1, 1, 0, 1'b0, 0);
        wait_idle();
        send_ok(2, 1, 8'h3C, 3, 1'b0, 8'hA5);
        @(posedge sys_clk); #1;
        check("lat_op_e1_valid", 64'(ch_op_valid), 64'd0);
        @(posedge sys_clk); #1;
        check("lat_op_e2_valid", 64'(ch_op_valid), 64'b0010);
        @(negedge sys_clk);
        wait_idle();

        // Disabled channel, then a write that is never accepted
        send_ok(1, 0, 8'h33, 1, 1'b0, 0);
        send_ok(1, 1, 8'h5C, 0, 1'b1, 0);
        wait_idle();

        // Illegal opcode and out-of-range channel, then saturation
        send_ok(9, 0, 0, 0, 1'b0, 0);
        send_ok(1, 7, 0, 0, 1'b0, 0);
        wait_idle();
        check("illegal_cnt_two", 64'(illegal_cnt), 64'd2);
        for (int i = 0; i < 300; i++)
            send_ok($urandom_range(5, 15), $urandom_range(0, 15), $urandom_range(0, 255), 0, 1'b0, 0);
        wait_idle();
        check("illegal_cnt_saturated", 64'(illegal_cnt), 64'd255);

        // Fill the queue while responses are held back
        rsp_hold = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            send(3, i % NUM_CH, i, 0, 1'b0, 0, 0, acc);
            if (!acc) break;
            n_acc++;
        end
        check("fill_accepted", 64'(n_acc), 64'(DEPTH + 1));
        check("fill_level", 64'(cmd_level), 64'(DEPTH));
        check("fill_ready_low", 64'(cmd_in_ready), 64'd0);
        fork
            send(4, 2, 1, 0, 1'b0, 0, 300, acc);
            begin
                repeat (4) @(negedge sys_clk);
                check("stall_level", 64'(cmd_level), 64'(DEPTH));
                check("stall_ready_low", 64'(cmd_in_ready), 64'd0);
                rsp_hold = 1'b0;
            end
        join
        check("stall_push_later_accepted", 64'(acc), 64'd1);
        wait_idle();

        // Randomized mix
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       op = 0;
                1, 5:    op = 1;
                2, 6, 9: op = 2;
                3:       op = 3;
                4, 7:    op = 4;
                default: op = $urandom_range(5, 15);
            endcase
            ch    = $urandom_range(0, NUM_CH);
            never = ($urandom_range(0, 49) == 0);
            send_ok(op, ch, $urandom_range(0, 255), $urandom_range(1, 6), never, $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge sys_clk);
        end
        wait_idle();

        // Reset in the middle of a pending channel operation
        send_ok(4, 1, 1, 0, 1'b0, 0);
        wait_idle();
        send_ok(1, 1, 8'h77, 0, 1'b1, 0);
        n = 0;
        while (!ch_op_valid[1] && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        check("pre_rst_op_valid", 64'(ch_op_valid), 64'b0010);
        for (int i = 0; i < 3; i++) send_ok(0, 0, 0, 0, 1'b0, 0);
        check("pre_rst_level", 64'(cmd_level), 64'd3);
        abort_op = 1'b1;
        #2 sys_rst = 1'b1;
        #1;
        check("mid_rst_op_valid", 64'(ch_op_valid), 64'd0);
        check("mid_rst_level", 64'(cmd_level), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        exp_q.delete();
        plan_q.delete();
        model_reset();
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("post_rst_mux_sel", 64'(mux_sel), 64'd0);
        check("post_rst_ch_clk_en", 64'(ch_clk_en), 64'd0);
        check("post_rst_cmd_in_ready", 64'(cmd_in_ready), 64'd1);
        check("post_rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
        repeat (3) @(negedge sys_clk);
        abort_op = 1'b0;

        // Parser still works after the reset
        send_ok(0, 0, 0, 0, 1'b0, 0);
        send_ok(1, 2, 8'h11, 1, 1'b0, 0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
